// File: rtl/restador_serie.sv
// restador_serie: multi-cycle subtractor, sal = (opea - opeb - bin) mod 2^WORD.
// Works on one DIGIT-bit slice per clock and keeps the borrow in a register
// between slices, so the critical path covers only DIGIT bits.
// Ports: clk and rst_n (asynchronous, active-low); inicio starts an operation
// and samples opea, opeb and bin. ocupado is high while computing. listo is a
// one-cycle completion pulse. sal, bout, cero, neg and ovf are the registered
// results and flags.
// Latency: N+1 edges (N = WORD/DIGIT) from the accepting edge until listo falls.
// Backpressure: inicio is ignored in CALC and is not queued. It is accepted in
// IDLE and in FIN, so a held inicio restarts with no IDLE cycle.
module restador_serie #(
  parameter int WORD  = 32,
  parameter int DIGIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inicio,
  input  logic [WORD-1:0] opea,
  input  logic [WORD-1:0] opeb,
  input  logic            bin,
  output logic            ocupado,
  output logic            listo,
  output logic [WORD-1:0] sal,
  output logic            bout,
  output logic            cero,
  output logic            neg,
  output logic            ovf
);

  localparam int N  = WORD / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} estado_t;

  estado_t         state_q;
  logic [WORD-1:0] a_q, b_q, part_q, sal_q;
  logic [CW-1:0]   cnt_q;
  logic            borrow_q;
  logic            msb_a_q, msb_b_q;   // operand sign bits, kept because a_q/b_q are shifted out
  logic            bout_q, cero_q, neg_q, ovf_q;

  logic [DIGIT:0]  slice_d;            // MSB is the borrow out of this slice
  logic [WORD-1:0] part_d;             // partial result after inserting this slice at the top
  logic            last_d;

  always_comb begin
    slice_d = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_q};
    part_d  = (part_q >> DIGIT) | (WORD'(slice_d[DIGIT-1:0]) << (WORD - DIGIT));
    last_d  = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      msb_a_q  <= 1'b0;
      msb_b_q  <= 1'b0;
      sal_q    <= '0;
      bout_q   <= 1'b0;
      cero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, FIN: begin
          if (inicio) begin
            a_q      <= opea;
            b_q      <= opeb;
            borrow_q <= bin;
            msb_a_q  <= opea[WORD-1];
            msb_b_q  <= opeb[WORD-1];
            part_q   <= '0;
            cnt_q    <= '0;
            state_q  <= CALC;
          end else begin
            state_q  <= IDLE;
          end
        end
        CALC: begin
          a_q      <= a_q >> DIGIT;
          b_q      <= b_q >> DIGIT;
          borrow_q <= slice_d[DIGIT];
          part_q   <= part_d;
          cnt_q    <= cnt_q + CW'(1);
          if (last_d) begin
            sal_q   <= part_d;
            bout_q  <= slice_d[DIGIT];
            cero_q  <= (part_d == '0);
            neg_q   <= part_d[WORD-1];
            ovf_q   <= (msb_a_q != msb_b_q) && (part_d[WORD-1] != msb_a_q);
            state_q <= FIN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ocupado = (state_q == CALC);
  assign listo   = (state_q == FIN);
  assign sal     = sal_q;
  assign bout    = bout_q;
  assign cero    = cero_q;
  assign neg     = neg_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_restador_serie.sv
// Bench for restador_serie: a default instance (DIGIT=4) and two more with
// DIGIT=1 and DIGIT=32. Expected results come from a whole-word reference
// model. For the default instance they pass through a scoreboard queue.
module tb_restador_serie;

  typedef struct packed {
    logic [31:0] sal;
    logic        bout;
    logic        cero;
    logic        neg;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ini0 = 1'b0, ini1 = 1'b0, ini32 = 1'b0;
  logic [31:0] opea = '0, opeb = '0;
  logic        bin = 1'b0;

  logic        ocup0, listo0, bout0, cero0, neg0, ovf0;
  logic [31:0] sal0;
  logic        ocup1, listo1, bout1, cero1, neg1, ovf1;
  logic [31:0] sal1;
  logic        ocup32, listo32, bout32, cero32, neg32, ovf32;
  logic [31:0] sal32;

  int   total = 0;
  int   bad = 0;
  res_t sb_q[$];

  always #5 clk = ~clk;

  restador_serie #(.WORD(32), .DIGIT(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .inicio(ini0), .opea(opea), .opeb(opeb), .bin(bin),
    .ocupado(ocup0), .listo(listo0), .sal(sal0), .bout(bout0), .cero(cero0), .neg(neg0), .ovf(ovf0));

  restador_serie #(.WORD(32), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .inicio(ini1), .opea(opea), .opeb(opeb), .bin(bin),
    .ocupado(ocup1), .listo(listo1), .sal(sal1), .bout(bout1), .cero(cero1), .neg(neg1), .ovf(ovf1));

  restador_serie #(.WORD(32), .DIGIT(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .inicio(ini32), .opea(opea), .opeb(opeb), .bin(bin),
    .ocupado(ocup32), .listo(listo32), .sal(sal32), .bout(bout32), .cero(cero32), .neg(neg32), .ovf(ovf32));

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic bi);
    logic [32:0] d;
    res_t r;
    d      = {1'b0, a} - {1'b0, b} - {32'd0, bi};
    r.sal  = d[31:0];
    r.bout = d[32];
    r.cero = (d[31:0] == 32'd0);
    r.neg  = d[31];
    r.ovf  = (a[31] != b[31]) && (d[31] != a[31]);
    return r;
  endfunction

  // Scoreboard: every listo pulse of the default instance must match the oldest pending result.
  always @(negedge clk) begin
    if (rst_n && listo0) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_listo: got sal=%h with no operation pending", sal0);
      end else begin
        res_t e;
        e = sb_q.pop_front();
        if ({sal0, bout0, cero0, neg0, ovf0} !== e) begin
          bad++;
          $display("FAIL sb_result: got sal=%h b=%b z=%b n=%b v=%b, want sal=%h b=%b z=%b n=%b v=%b",
                   sal0, bout0, cero0, neg0, ovf0, e.sal, e.bout, e.cero, e.neg, e.ovf);
        end
      end
    end
  end

  // Presents operands with inicio high for exactly one edge of the default instance.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic bi, input bit push);
    @(negedge clk);
    opea = a; opeb = b; bin = bi; ini0 = 1'b1;
    if (push) sb_q.push_back(model(a, b, bi));
    @(posedge clk);
    #1 ini0 = 1'b0;
  endtask

  // Counts busy cycles and returns the cycle (after the accepting edge) where listo is seen; -1 on timeout.
  task automatic wait_done(output int busy, output int done_at);
    busy = 0; done_at = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ocup0) busy++;
      if (listo0) begin
        done_at = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({ocup0, listo0, sal0, bout0, cero0, neg0, ovf0} !== 38'd0) begin
      bad++;
      $display("FAIL reset_outputs: got ocup=%b listo=%b sal=%h flags=%b%b%b%b, want all 0",
               ocup0, listo0, sal0, bout0, cero0, neg0, ovf0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_arith();
    logic [31:0] ta[9];
    logic [31:0] tb[9];
    logic        tbi[9];
    int busy, done_at;
    ta[0] = 32'd10;         tb[0] = 32'd3;          tbi[0] = 1'b0;
    ta[1] = 32'd0;          tb[1] = 32'd1;          tbi[1] = 1'b0;
    ta[2] = 32'h8000_0000;  tb[2] = 32'd1;          tbi[2] = 1'b0;
    ta[3] = 32'd5;          tb[3] = 32'd4;          tbi[3] = 1'b1;
    ta[4] = 32'h7FFF_FFFF;  tb[4] = 32'hFFFF_FFFF;  tbi[4] = 1'b0;
    for (int i = 5; i < 9; i++) begin
      ta[i] = $urandom; tb[i] = $urandom; tbi[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 9; i++) begin
      start_op(ta[i], tb[i], tbi[i], 1'b1);
      wait_done(busy, done_at);
      total++;
      if (busy !== 8 || done_at !== 9) begin
        bad++;
        $display("FAIL arith_timing[%0d]: got busy=%0d listo_cycle=%0d, want busy=8 listo_cycle=9", i, busy, done_at);
      end
      @(negedge clk);
      total++;
      if (listo0 !== 1'b0 || ocup0 !== 1'b0) begin
        bad++;
        $display("FAIL arith_pulse[%0d]: got listo=%b ocup=%b after completion, want 0 0", i, listo0, ocup0);
      end
    end
  endtask

  task automatic test_ignore_in_calc();
    int pulses;
    logic [31:0] held;
    start_op(32'd100, 32'd58, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    opea = 32'hDEAD_BEEF; opeb = 32'd7; ini0 = 1'b1;
    @(posedge clk);
    #1 ini0 = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (listo0) pulses++;
    end
    total++;
    if (pulses !== 1) begin
      bad++;
      $display("FAIL ignore_listo_count: got %0d pulses, want 1", pulses);
    end
    held = sal0;
    total++;
    if (held !== 32'd42 || ocup0 !== 1'b0) begin
      bad++;
      $display("FAIL ignore_idle_hold: got sal=%h ocup=%b, want sal=0000002a ocup=0", held, ocup0);
    end
  endtask

  task automatic test_back_to_back();
    res_t ea;
    ea = model(32'h1234_5678, 32'h1111_1111, 1'b0);
    @(negedge clk);
    opea = 32'h1234_5678; opeb = 32'h1111_1111; bin = 1'b0; ini0 = 1'b1;
    sb_q.push_back(ea);
    @(posedge clk);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 4) begin
        opea = 32'h7FFF_FFFF; opeb = 32'hFFFF_FFFF; bin = 1'b0;
        sb_q.push_back(model(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0));
      end
      if (k >= 9 && k <= 17) begin
        total++;
        if (sal0 !== ea.sal) begin
          bad++;
          $display("FAIL b2b_sal_stable[%0d]: got %h, want %h", k, sal0, ea.sal);
        end
      end
      if (k == 9 || k == 18) begin
        total++;
        if (listo0 !== 1'b1) begin
          bad++;
          $display("FAIL b2b_listo[%0d]: got %b, want 1", k, listo0);
        end
      end
      if (k == 10) begin
        total++;
        if (ocup0 !== 1'b1) begin
          bad++;
          $display("FAIL b2b_no_idle: got ocup=%b in cycle 10, want 1", ocup0);
        end
      end
      if (k == 9) begin
        @(posedge clk);
        #1 ini0 = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_calc();
    int pulses, busy, done_at;
    start_op(32'd77, 32'd11, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({ocup0, listo0, sal0, bout0, cero0, neg0, ovf0} !== 38'd0) begin
      bad++;
      $display("FAIL reset_mid_outputs: got ocup=%b listo=%b sal=%h flags=%b%b%b%b, want all 0",
               ocup0, listo0, sal0, bout0, cero0, neg0, ovf0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (listo0 || ocup0) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL reset_mid_abort: got %0d busy/listo cycles after reset, want 0", pulses);
    end
    start_op(32'd1000, 32'd1, 1'b0, 1'b1);
    wait_done(busy, done_at);
    total++;
    if (done_at !== 9) begin
      bad++;
      $display("FAIL reset_mid_restart: got listo_cycle=%0d, want 9", done_at);
    end
    @(negedge clk);
  endtask

  task automatic test_digit_widths();
    int busy1, busy32, done1, done32;
    res_t e, got1, got32;
    e = model(32'd0, 32'd1, 1'b0);
    busy1 = 0; busy32 = 0; done1 = -1; done32 = -1;
    got1 = '0; got32 = '0;
    @(negedge clk);
    opea = 32'd0; opeb = 32'd1; bin = 1'b0; ini1 = 1'b1; ini32 = 1'b1;
    @(posedge clk);
    #1 begin ini1 = 1'b0; ini32 = 1'b0; end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ocup1) busy1++;
      if (ocup32) busy32++;
      if (listo1 && done1 < 0) begin done1 = k; got1 = {sal1, bout1, cero1, neg1, ovf1}; end
      if (listo32 && done32 < 0) begin done32 = k; got32 = {sal32, bout32, cero32, neg32, ovf32}; end
    end
    total++;
    if (busy1 !== 32 || done1 !== 33) begin
      bad++;
      $display("FAIL digit1_timing: got busy=%0d listo_cycle=%0d, want busy=32 listo_cycle=33", busy1, done1);
    end
    total++;
    if (got1 !== e) begin
      bad++;
      $display("FAIL digit1_result: got %h, want %h", got1, e);
    end
    total++;
    if (busy32 !== 1 || done32 !== 2) begin
      bad++;
      $display("FAIL digit32_timing: got busy=%0d listo_cycle=%0d, want busy=1 listo_cycle=2", busy32, done32);
    end
    total++;
    if (got32 !== e) begin
      bad++;
      $display("FAIL digit32_result: got %h, want %h", got32, e);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_ignore_in_calc();
    test_back_to_back();
    test_reset_mid_calc();
    test_digit_widths();
    repeat (2) @(negedge clk);
    total++;
    if (sb_q.size() !== 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d results never produced, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/restador_serie.md
# restador_serie

Multi-cycle subtractor for the Monociclo ALU datapath, the inverse operation of the ripple adder. It computes `opea - opeb - bin` one DIGIT-bit slice per clock, propagating borrow through a register between slices, which keeps the critical path at DIGIT bits. It is controlled by a start/busy/done handshake and reports borrow-out plus zero, negative and signed-overflow flags.

## Interface
- WORD, 32, operand and result width
- DIGIT, 4, bits processed per cycle; WORD % DIGIT == 0 required, DIGIT == WORD allowed; N = WORD/DIGIT cycles of computation
- clk  input  1  sole clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- inicio  input  1  start request, sampled on rising edge
- opea  input  WORD  minuend, sampled with accepted inicio
- opeb  input  WORD  subtrahend, sampled with accepted inicio
- bin  input  1  borrow in, sampled with accepted inicio
- ocupado  output  1  high while computing (state CALC)
- listo  output  1  one-cycle completion pulse
- sal  output  WORD  result, (opea - opeb - bin) mod 2^WORD
- bout  output  1  borrow out; 1 iff opea < opeb + bin (unsigned)
- cero  output  1  sal == 0
- neg  output  1  sal[WORD-1]
- ovf  output  1  signed overflow: opea[WORD-1] != opeb[WORD-1] and sal[WORD-1] != opea[WORD-1]

## Operation
- States: IDLE, CALC, FIN. Reset state is IDLE.
- IDLE, inicio=1:
  - latch opea, opeb into shift registers
  - load bin into the borrow register
  - clear the slice counter
  - go to CALC
- IDLE, inicio=0: stay in IDLE.
- CALC, each edge:
  - take the low DIGIT bits of each operand: d = a_slice - b_slice - borrow
  - shift the DIGIT-bit result into the partial register from the top
  - borrow <= borrow out of slice d
  - shift both operand registers right by DIGIT
  - increment the counter
- CALC, edge that processes slice N-1:
  - write the full result to sal
  - write the final borrow to bout
  - write cero, neg, ovf
  - go to FIN
- ovf uses the MSBs of the latched operands; keep a copy of them, since the shift registers are consumed.
- FIN lasts exactly one cycle; listo=1.
  - inicio=1 in FIN is accepted as a new start (same action as IDLE, go to CALC).
  - Otherwise go to IDLE.
- inicio while in CALC is ignored. It is not queued.
- sal, bout, cero, neg, ovf change only on the completion edge. They hold their value through IDLE and through the next CALC until the next completion.
- Reset, at any time including mid-CALC:
  - aborts the operation
  - state IDLE
  - ocupado=0, listo=0
  - sal=0, bout=0, cero=0, neg=0, ovf=0
  - internal registers cleared
  - no listo pulse for the aborted operation

## Timing
- All outputs are registered (or decoded from the state register); no combinational path from inputs to outputs.
- Start accepted at edge E0.
  - ocupado is high from E0 to E0+N.
  - Results update at edge E0+N.
  - listo is high from E0+N to E0+N+1.
- Latency: N+1 edges from the accepting edge to listo deassertion. Defaults (N=8): listo is high in the 9th cycle after start.
- Throughput: one operation per N+1 cycles when inicio is held high continuously (restart in FIN).
- DIGIT == WORD: N=1, so CALC lasts one cycle and listo follows one cycle after start.
- Output reset values: all outputs 0.

## Test plan
- 10 - 3, bin=0 (defaults) -> sal=7; bout=0, cero=0, neg=0, ovf=0; ocupado high 8 cycles; listo high exactly in cycle 9.
- 0 - 1, bin=0 -> sal=0xFFFFFFFF; bout=1, neg=1, ovf=0, cero=0.
- 0x80000000 - 1 -> sal=0x7FFFFFFF; ovf=1, neg=0, bout=0.
- 5 - 4, bin=1 -> sal=0, cero=1, bout=0. Then 0x7FFFFFFF - 0xFFFFFFFF -> sal=0x80000000, ovf=1, bout=1.
- Control sequence:
  - pulse inicio again during CALC -> ignored, single listo
  - hold inicio high through FIN -> second operation starts with no IDLE cycle
  - sal stays stable between completions
- Reset mid-CALC (cycle 4) -> all outputs 0 immediately, no listo. A new start then completes correctly. Repeat the 0 - 1 case with DIGIT=1 (32 cycles) and DIGIT=32 (1 cycle) -> same results.
